// File: rtl/pc_flow_ctrl.sv
// Fetch-flow controller: decides PC advance/hold/redirect each cycle, drives
// IF/ID hold/flush and ID/EX bubble, and parks a redirect that arrives while
// instruction memory is still busy until the fetch completes.
module pc_flow_ctrl #(
  parameter int unsigned MEM_SPACE = 16,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 imem_ready,
  input  logic                 id_is_jump,
  input  logic [MEM_SPACE-1:0] id_jump_target,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 ex_is_load,
  input  logic                 ex_reg_write,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic                 ex_br_taken,
  input  logic [MEM_SPACE-1:0] ex_br_target,
  output logic                 PChold,
  output logic                 pc_redirect,
  output logic [MEM_SPACE-1:0] pc_target,
  output logic                 ifid_hold,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [MEM_SPACE-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic [CNT_W-1:0]       flush_q, flush_d;
  logic                   lu;

  // Load-use hazard: EX load result is needed by the instruction in ID.
  assign lu = ex_is_load & ex_reg_write & (ex_rd != '0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Next state and zero-latency control outputs; everything forced low in reset.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    PChold      = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (Rst) begin
      unique case (state_q)
        RUN: begin
          if (imem_ready) begin
            if (ex_br_taken) begin
              pc_redirect = 1'b1;
              pc_target   = ex_br_target;
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end else if (lu) begin
              PChold      = 1'b1;
              ifid_hold   = 1'b1;
              idex_bubble = 1'b1;
            end else if (id_is_jump) begin
              pc_redirect = 1'b1;
              pc_target   = id_jump_target;
              ifid_flush  = 1'b1;
            end
          end else begin
            PChold = 1'b1;
            if (lu) begin
              ifid_hold   = 1'b1;
              idex_bubble = 1'b1;
            end else begin
              ifid_flush  = 1'b1;
            end
            if (ex_br_taken) begin
              pend_d      = ex_br_target;
              idex_bubble = 1'b1;
              state_d     = PEND;
            end else if (!lu && id_is_jump) begin
              pend_d      = id_jump_target;
              state_d     = PEND;
            end
          end
        end
        PEND: begin
          PChold     = 1'b1;
          ifid_flush = 1'b1;
          if (ex_br_taken) begin
            pend_d      = ex_br_target;
            idex_bubble = 1'b1;
          end
          if (imem_ready) begin
            PChold      = 1'b0;
            pc_redirect = 1'b1;
            pc_target   = ex_br_taken ? ex_br_target : pend_q;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating performance counters for hold and redirect cycles.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (PChold && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (pc_redirect && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  // State, pending target and counter registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= RUN;
      pend_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
